// File: rtl/alu_issue_stage.sv
// ALU issue buffer: a small FIFO of decoded ALU operations with operand forwarding.
// Define ALU_ISSUE_FWD_EN to build capture forwarding and held-entry writeback snooping.
module alu_issue_stage #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           rs1_data,
    input  logic [XLEN-1:0]           rs2_data,
    input  logic [XLEN-1:0]           imm,
    input  logic [4:0]                rs1_addr,
    input  logic [4:0]                rs2_addr,
    input  logic [4:0]                rd_addr,
    input  logic [1:0]                alu_op,
    input  logic [2:0]                funct3,
    input  logic                      funct7_5,
    input  logic                      alu_src,
    input  logic                      exmem_regwrite,
    input  logic [4:0]                exmem_rd,
    input  logic [XLEN-1:0]           exmem_result,
    input  logic                      memwb_regwrite,
    input  logic [4:0]                memwb_rd,
    input  logic [XLEN-1:0]           memwb_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           a,
    output logic [XLEN-1:0]           b,
    output logic [3:0]                Alu_control,
    output logic [4:0]                rd_out,
    output logic [XLEN-1:0]           store_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
`ifdef ALU_ISSUE_FWD_EN
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
`endif
        logic [4:0]      rd;
        logic            alu_src;
        logic [3:0]      ctrl;
    } entry_t;

    entry_t          mem      [DEPTH];
    entry_t          mem_next [DEPTH];
    entry_t          new_entry;
    entry_t          head;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count_q;
    logic            push, pop;

    function automatic logic [3:0] decode_ctrl(input logic [1:0] op, input logic [2:0] f3,
                                               input logic f7);
        logic [3:0] ctrl;
        ctrl = 4'b1111;
        case (op)
            2'b00: ctrl = 4'b0000;
            2'b01: ctrl = 4'b0001;
            2'b10: begin
                case (f3)
                    3'b000:  ctrl = f7 ? 4'b0001 : 4'b0000;
                    3'b111:  ctrl = 4'b0010;
                    3'b110:  ctrl = 4'b0011;
                    default: ctrl = 4'b1111;
                endcase
            end
            default: ctrl = 4'b1111;
        endcase
        return ctrl;
    endfunction

`ifdef ALU_ISSUE_FWD_EN
    // EX/MEM is the younger result, so it wins over MEM/WB; x0 is never forwarded.
    function automatic logic [XLEN-1:0] resolve(input logic [4:0] addr,
                                                input logic [XLEN-1:0] cur);
        logic [XLEN-1:0] val;
        val = cur;
        if (exmem_regwrite && exmem_rd == addr && addr != 5'd0)
            val = exmem_result;
        else if (memwb_regwrite && memwb_rd == addr && addr != 5'd0)
            val = memwb_result;
        return val;
    endfunction
`else
    logic unused_snoop;
    assign unused_snoop = ^{exmem_regwrite, exmem_rd, exmem_result,
                            memwb_regwrite, memwb_rd, memwb_result, rs1_addr, rs2_addr};
`endif

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        new_entry         = '0;
`ifdef ALU_ISSUE_FWD_EN
        new_entry.rs1_val  = resolve(rs1_addr, rs1_data);
        new_entry.rs2_val  = resolve(rs2_addr, rs2_data);
        new_entry.rs1_addr = rs1_addr;
        new_entry.rs2_addr = rs2_addr;
`else
        new_entry.rs1_val  = rs1_data;
        new_entry.rs2_val  = rs2_data;
`endif
        new_entry.imm     = imm;
        new_entry.rd      = rd_addr;
        new_entry.alu_src = alu_src;
        new_entry.ctrl    = decode_ctrl(alu_op, funct3, funct7_5);
    end

    // The slot being written is never a held entry, so capture simply replaces the snoop result.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_next[i] = mem[i];
`ifdef ALU_ISSUE_FWD_EN
            mem_next[i].rs1_val = resolve(mem[i].rs1_addr, mem[i].rs1_val);
            mem_next[i].rs2_val = resolve(mem[i].rs2_addr, mem[i].rs2_val);
`endif
            if (push && !flush && wr_ptr == PW'(i))
                mem_next[i] = new_entry;
        end
    end

    // NOTE: entry storage has no reset; occupancy gates every output, so stale data is never seen.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            mem[i] <= mem_next[i];
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else if (flush) begin
            count_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        a           = '0;
        b           = '0;
        store_data  = '0;
        Alu_control = 4'b1111;
        rd_out      = '0;
        if (out_valid) begin
            a           = head.rs1_val;
            b           = head.alu_src ? head.imm : head.rs2_val;
            store_data  = head.rs2_val;
            Alu_control = head.ctrl;
            rd_out      = head.rd;
        end
    end

endmodule
